// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler: FSM states,
// packet length width and default line timing.
package uart_tx_scheduler_pkg;

  localparam int unsigned LEN_W           = 10;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned DEF_BYTE_CYCLES = 20;
  localparam int unsigned DEF_WAKE_CYCLES = 1;
  localparam int unsigned DEF_GAP_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_KICK,
    ST_SEND,
    ST_GAP
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// pointer+1 with wrap-around. The caller owns and updates the pointer.
module uart_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index,
  output logic            found
);

  int unsigned     cand;
  logic [IW-1:0]   cidx;

  always_comb begin
    grant = '0;
    index = pointer;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(pointer) + i) % NREQ;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        index       = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one open-loop paced UART transmitter between NREQ clients with
// packet-level round-robin arbitration.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned BYTE_CYCLES = DEF_BYTE_CYCLES,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_data_valid,
  output logic [NREQ-1:0]         req_data_ready,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    underrun,
  output logic                    busy,
  output logic [LEN_W-1:0]        bytes_to_tx,
  output logic [7:0]              tx_data_byte,
  output logic                    tx_data_valid
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned SW = LEN_W + 1;
  localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(WAKE_CYCLES + BYTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BYTE_LOAD  = CNT_W'(BYTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win_idx;
  logic [NREQ-1:0]   win_onehot;
  logic              win_found;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero, cnt_one;
  logic [SW-1:0]     sent;
  logic [7:0]        hold;
  logic              last_byte;
  logic              fetch_point;
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic [7:0]        data_arr [NREQ];
  logic [LEN_W-1:0]  len_arr  [NREQ];

  uart_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req),
    .pointer (ptr),
    .grant   (win_onehot),
    .index   (win_idx),
    .found   (win_found)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*8 +: 8];
      len_arr[i]  = req_len[i*LEN_W +: LEN_W];
    end
  end

  // ptr holds the current winner for the whole packet, so it also selects its data.
  assign byte_valid = req_data_valid[ptr];
  assign byte_in    = byte_valid ? data_arr[ptr] : 8'hFF;
  assign cnt_zero   = (cnt == '0);
  assign cnt_one    = (cnt == CNT_W'(1));
  assign last_byte  = (sent == ({1'b0, bytes_to_tx} + SW'(1)));
  assign fetch_point = (state == ST_FETCH) ||
                       (((state == ST_KICK) || (state == ST_SEND)) && cnt_one && !last_byte);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (win_found) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_KICK;
      ST_KICK:  state_nxt = ST_SEND;
      ST_SEND:  if (cnt_zero && last_byte) state_nxt = ST_GAP;
      ST_GAP:   if (cnt_zero) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_data_ready = '0;
    underrun       = 1'b0;
    tx_data_valid  = (state == ST_KICK);
    if (fetch_point) begin
      req_data_ready = grant;
      underrun       = !byte_valid;
    end
  end

  // The byte popped at count==1 is parked in hold and shown on the line at count==0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= '0;
      done         <= '0;
      busy         <= 1'b0;
      bytes_to_tx  <= '0;
      tx_data_byte <= '0;
      ptr          <= IW'(NREQ - 1);
      cnt          <= '0;
      sent         <= '0;
      hold         <= '0;
    end else begin
      done <= '0;
      unique case (state)
        ST_IDLE: begin
          if (win_found) begin
            grant       <= win_onehot;
            busy        <= 1'b1;
            bytes_to_tx <= len_arr[win_idx];
            ptr         <= win_idx;
          end
        end
        ST_FETCH: begin
          tx_data_byte <= byte_in;
          sent         <= SW'(1);
          cnt          <= FIRST_LOAD;
        end
        ST_KICK, ST_SEND: begin
          if (fetch_point) hold <= byte_in;
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (state == ST_SEND) begin
            if (last_byte) begin
              cnt <= GAP_LOAD;
            end else begin
              tx_data_byte <= hold;
              sent         <= sent + SW'(1);
              cnt          <= BYTE_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            done  <= grant;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
